// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and the datapath.
// The controller owns the control strobes and state; the datapath supplies instr and Zero.
interface multicycle_ctrl_if;
  logic [31:0] instr;
  logic        Zero;
  logic        PCSrc;
  logic        ALUSrc;
  logic        RegWrite;
  logic        MemToReg;
  logic [3:0]  ALUCtrl;
  logic        loadPC;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  state;
  logic [31:0] retired;

  modport master (
    input  instr, Zero,
    output PCSrc, ALUSrc, RegWrite, MemToReg, ALUCtrl, loadPC,
           MemRead, MemWrite, state, retired
  );

  modport slave (
    output instr, Zero,
    input  PCSrc, ALUSrc, RegWrite, MemToReg, ALUCtrl, loadPC,
           MemRead, MemWrite, state, retired
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Five-state multicycle control unit: fixed IF/ID/EX/MEM/WB sequencing, with a
// combinational instruction decode and commit strobes confined to MEM/WB.
module multicycle_ctrl (
  input  logic                   clk,
  input  logic                   rst,
  multicycle_ctrl_if.master      bus
);
  localparam logic [6:0] OPC_R  = 7'b0110011;
  localparam logic [6:0] OPC_I  = 7'b0010011;
  localparam logic [6:0] OPC_LW = 7'b0000011;
  localparam logic [6:0] OPC_S  = 7'b0100011;
  localparam logic [6:0] OPC_B  = 7'b1100011;

  localparam logic [2:0] S_IF  = 3'd0;
  localparam logic [2:0] S_ID  = 3'd1;
  localparam logic [2:0] S_EX  = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB  = 3'd4;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;

  logic [2:0]  state_q;
  logic [2:0]  state_d;
  logic [31:0] retired_cnt;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        unused_instr_bits;

  logic [3:0]  alu_ctrl;
  logic        alu_src;
  logic        mem_to_reg;
  logic        writes_reg;
  logic        is_lw;
  logic        is_sw;
  logic        is_beq;
  logic        in_mem;
  logic        in_wb;

  assign opcode            = bus.instr[6:0];
  assign funct3            = bus.instr[14:12];
  assign funct7b5          = bus.instr[30];
  assign unused_instr_bits = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

  // Shared funct3 mapping for R and I formats; returns {supported, op}.
  function automatic logic [4:0] alu_map(input logic [2:0] f3, input logic f7b5,
                                         input logic allow_sub);
    logic [4:0] r;
    r = {1'b1, ALU_ADD};
    case (f3)
      3'b000:  r = {1'b1, (allow_sub && f7b5) ? ALU_SUB : ALU_ADD};
      3'b111:  r = {1'b1, ALU_AND};
      3'b110:  r = {1'b1, ALU_OR};
      3'b100:  r = {1'b1, ALU_XOR};
      3'b010:  r = {1'b1, ALU_SLT};
      3'b001:  r = {1'b1, ALU_SLL};
      3'b101:  r = {1'b1, f7b5 ? ALU_SRA : ALU_SRL};
      default: r = {1'b0, ALU_ADD};
    endcase
    return r;
  endfunction

  always_comb begin
    logic [4:0] m;
    alu_ctrl   = ALU_ADD;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    writes_reg = 1'b0;
    is_lw      = 1'b0;
    is_sw      = 1'b0;
    is_beq     = 1'b0;
    m          = '0;
    case (opcode)
      OPC_R: begin
        m = alu_map(funct3, funct7b5, 1'b1);
        if (m[4]) begin
          alu_ctrl   = m[3:0];
          writes_reg = 1'b1;
        end
      end
      OPC_I: begin
        m = alu_map(funct3, funct7b5, 1'b0);
        if (m[4]) begin
          alu_ctrl   = m[3:0];
          alu_src    = 1'b1;
          writes_reg = 1'b1;
        end
      end
      OPC_LW: if (funct3 == 3'b010) begin
        alu_src    = 1'b1;
        mem_to_reg = 1'b1;
        writes_reg = 1'b1;
        is_lw      = 1'b1;
      end
      OPC_S: if (funct3 == 3'b010) begin
        alu_src = 1'b1;
        is_sw   = 1'b1;
      end
      OPC_B: if (funct3 == 3'b000) begin
        alu_ctrl = ALU_SUB;
        is_beq   = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (state_q)
      S_IF:    state_d = S_ID;
      S_ID:    state_d = S_EX;
      S_EX:    state_d = S_MEM;
      S_MEM:   state_d = S_WB;
      default: state_d = S_IF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IF;
      retired_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_WB)
        retired_cnt <= retired_cnt + 32'd1;
    end
  end

  // Gating with rst keeps a reset that lands in MEM/WB from committing at that edge.
  assign in_mem = rst && (state_q == S_MEM);
  assign in_wb  = rst && (state_q == S_WB);

  assign bus.ALUCtrl  = alu_ctrl;
  assign bus.ALUSrc   = alu_src;
  assign bus.MemToReg = mem_to_reg;
  assign bus.MemRead  = in_mem && is_lw;
  assign bus.MemWrite = in_mem && is_sw;
  assign bus.RegWrite = in_wb && writes_reg;
  assign bus.loadPC   = in_wb;
  assign bus.PCSrc    = in_wb && is_beq && bus.Zero;
  assign bus.state    = state_q;
  assign bus.retired  = retired_cnt;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes per-cycle expected outputs,
// a negedge monitor pops and compares them.
module tb_multicycle_ctrl;
  logic clk;
  logic rst;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  state;
    logic [3:0]  alu;
    logic        src;
    logic        m2r;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        lpc;
    logic        pcs;
    logic [31:0] ret;
  } exp_t;

  exp_t exp_q[$];
  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;
  logic [31:0] exp_ret = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("state",    {29'd0, bus.state},    {29'd0, e.state});
      chk("ALUCtrl",  {28'd0, bus.ALUCtrl},  {28'd0, e.alu});
      chk("ALUSrc",   {31'd0, bus.ALUSrc},   {31'd0, e.src});
      chk("MemToReg", {31'd0, bus.MemToReg}, {31'd0, e.m2r});
      chk("RegWrite", {31'd0, bus.RegWrite}, {31'd0, e.rw});
      chk("MemRead",  {31'd0, bus.MemRead},  {31'd0, e.mr});
      chk("MemWrite", {31'd0, bus.MemWrite}, {31'd0, e.mw});
      chk("loadPC",   {31'd0, bus.loadPC},   {31'd0, e.lpc});
      chk("PCSrc",    {31'd0, bus.PCSrc},    {31'd0, e.pcs});
      chk("retired",  bus.retired,           e.ret);
    end
  end

  function automatic exp_t mk(input logic [2:0] st, input logic [3:0] alu, input logic src,
                              input logic m2r, input logic rw, input logic mr,
                              input logic mw, input logic lpc, input logic pcs);
    exp_t e;
    e.state = st; e.alu = alu; e.src = src; e.m2r = m2r;
    e.rw = rw; e.mr = mr; e.mw = mw; e.lpc = lpc; e.pcs = pcs; e.ret = exp_ret;
    return e;
  endfunction

  // Entered #1 into an IF cycle; leaves #1 into the next IF cycle.
  task automatic run_instr(input logic [31:0] ins, input logic zero, input logic [3:0] alu,
                           input logic src, input logic m2r, input logic rw,
                           input logic mr, input logic mw, input logic pcs);
    bus.instr = ins;
    bus.Zero  = zero;
    for (int unsigned st = 0; st < 5; st++) begin
      exp_q.push_back(mk(st[2:0], alu, src, m2r,
                         rw && st == 4, (mr && st == 3), (mw && st == 3),
                         st == 4, pcs && st == 4));
      @(posedge clk); #1;
      if (st == 4) exp_ret = exp_ret + 32'd1;
    end
  endtask

  initial begin
    rst       = 1'b0;
    bus.instr = 32'h002081B3;
    bus.Zero  = 1'b0;

    // Reset held across three sampled edges.
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mk(3'd0, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      @(posedge clk); #1;
    end
    rst = 1'b1;

    // ADD interrupted by reset during MEM: no commit, back to IF.
    for (int unsigned st = 0; st < 3; st++) begin
      exp_q.push_back(mk(st[2:0], 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      @(posedge clk); #1;
    end
    rst = 1'b0;
    exp_q.push_back(mk(3'd3, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(posedge clk); #1;
    rst = 1'b1;

    //          instr         Z     ALU      src   m2r   rw    mr    mw    pcs
    run_instr(32'h002081B3, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); // add
    run_instr(32'h402081B3, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); // sub
    run_instr(32'h0040A183, 1'b0, 4'b0010, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); // lw
    run_instr(32'h0030A223, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); // sw
    run_instr(32'h00208463, 1'b1, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); // beq taken
    run_instr(32'h00208463, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // beq not taken
    run_instr(32'h40315093, 1'b0, 4'b1010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); // srai
    run_instr(32'h0FF17093, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); // andi
    run_instr(32'h00209463, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // bne: unsupported
    run_instr(32'h0000007F, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // bad opcode

    // Preload the retire counter just below wrap.
    force dut.retired_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.retired_cnt;
    exp_ret = 32'hFFFF_FFFE;
    run_instr(32'h0000007F, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_instr(32'h002081B3, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(mk(3'd0, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(posedge clk); #1;

    if (exp_q.size() != 0) begin
      total_cnt++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
